// File: rtl/johnson_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : johnson_pkg                                               |
// | Purpose  : Shared state codes and Johnson-ring helper functions.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package johnson_pkg;

   // Helpers work on a zero-extended vector of this width; callers cast
   // their ring into and out of it.
   localparam int MAX_W = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef logic [1:0] state_t;

   // One twisted-ring step over the low w bits: shift up, feed back ~msb.
   function automatic logic [MAX_W-1:0] johnson_next(input logic [MAX_W-1:0] o,
                                                     input int w);
      logic [MAX_W-1:0] r;
      r = '0;
      for (int i = 1; i < MAX_W; i++) begin
         if (i < w) r[i] = o[i-1];
      end
      r[0] = ~o[w-1];
      return r;
   endfunction

   // One-hot phase: bit k set when o equals the code reached after k steps
   // from all-zero. All-zero result for any code outside the ring.
   function automatic logic [2*MAX_W-1:0] johnson_decode(input logic [MAX_W-1:0] o,
                                                         input int w);
      logic [2*MAX_W-1:0] p;
      logic [MAX_W-1:0]   code;
      p    = '0;
      code = '0;
      for (int k = 0; k < 2*MAX_W; k++) begin
         if (k < 2*w) begin
            if (o == code) p[k] = 1'b1;
            code = johnson_next(code, w);
         end
      end
      return p;
   endfunction

   function automatic logic johnson_legal(input logic [MAX_W-1:0] o, input int w);
      return |johnson_decode(o, w);
   endfunction

endpackage
`default_nettype wire

// File: rtl/johnson_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : johnson_core                                              |
// | Purpose  : WIDTH-bit Johnson ring with step enable, synchronous clear |
// |            and self-correction of illegal codes.                     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module johnson_core
   import johnson_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_ring,
   output logic             o_wrap_now
);

   localparam int EXT_W = MAX_W;

   logic [WIDTH-1:0] ring_q;
   logic [WIDTH-1:0] ring_d;
   logic [WIDTH-1:0] w_step;
   logic             w_legal;

   // Candidate next code and legality of the present code.
   always_comb begin
      w_step  = WIDTH'(johnson_next(EXT_W'(ring_q), WIDTH));
      w_legal = johnson_legal(EXT_W'(ring_q), WIDTH);
   end

   // Clear and illegal-code recovery take precedence over stepping.
   always_comb begin
      ring_d = ring_q;
      if (i_clr || !w_legal) begin
         ring_d = '0;
      end else if (i_en) begin
         ring_d = w_step;
      end
   end

   // Ring register.
   always_ff @(posedge clk) begin
      if (rst) ring_q <= '0;
      else     ring_q <= ring_d;
   end

   assign o_ring     = ring_q;
   // A step taken now would land the ring back on all-zero.
   assign o_wrap_now = w_legal && (w_step == '0);

endmodule
`default_nettype wire

// File: rtl/johnson_phase_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : johnson_phase_sequencer                                   |
// | Purpose  : Runs a Johnson ring for a programmed number of             |
// |            revolutions with start/busy/done, hold and stop.          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module johnson_phase_sequencer
   import johnson_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int CNT_W = 8
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               start,
   input  logic [CNT_W-1:0]   cycles,
   input  logic               hold,
   input  logic               stop,
   output logic [WIDTH-1:0]   O,
   output logic [2*WIDTH-1:0] phase,
   output logic               wrap,
   output logic               busy,
   output logic               done
);

   localparam int EXT_W = MAX_W;

   state_t           state_q,     state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic             wrap_q,      wrap_d;
   logic             core_en;
   logic             core_clr;
   logic             wrap_now;
   logic [WIDTH-1:0] ring;

   johnson_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk        (CLK),
      .rst        (RESET),
      .i_en       (core_en),
      .i_clr      (core_clr),
      .o_ring     (ring),
      .o_wrap_now (wrap_now)
   );

   // Sequencer: stop beats hold beats stepping; ring is held clear outside RUN/HOLD.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      wrap_d      = 1'b0;
      core_en     = 1'b0;
      core_clr    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            core_clr = 1'b1;
            if (start) begin
               if (cycles == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d     = ST_RUN;
                  remaining_d = cycles;
               end
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d     = ST_IDLE;
               core_clr    = 1'b1;
               remaining_d = '0;
            end else if (hold) begin
               state_d = ST_HOLD;
            end else begin
               core_en = 1'b1;
               if (wrap_now) begin
                  wrap_d = 1'b1;
                  if (remaining_q != '0) remaining_d = remaining_q - CNT_W'(1);
                  if (remaining_q <= CNT_W'(1)) state_d = ST_DONE;
               end
            end
         end
         ST_HOLD: begin
            if (stop) begin
               state_d     = ST_IDLE;
               core_clr    = 1'b1;
               remaining_d = '0;
            end else if (!hold) begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            core_clr = 1'b1;
            state_d  = ST_IDLE;
         end
         default: begin
            core_clr = 1'b1;
            state_d  = ST_IDLE;
         end
      endcase
   end

   // State, revolution counter and wrap flag.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         wrap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         wrap_q      <= wrap_d;
      end
   end

   assign O     = ring;
   assign phase = (2*WIDTH)'(johnson_decode(EXT_W'(ring), WIDTH));
   assign wrap  = wrap_q;
   assign busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);
   assign done  = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_johnson_phase_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_johnson_phase_sequencer                                |
// | Purpose  : Self-checking bench for johnson_phase_sequencer.           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_johnson_phase_sequencer;

   logic       CLK = 1'b0;
   logic       RESET, start, hold, stop;
   logic [7:0] cycles;
   logic [1:0] O;
   logic [3:0] phase;
   logic       wrap, busy, done;

   logic       r3, s3, h3, p3;
   logic [7:0] c3;
   logic [2:0] O3;
   logic [5:0] ph3;
   logic       w3, b3, d3;

   int checks = 0;
   int errors = 0;
   int bcnt, dcnt, wcnt;

   johnson_phase_sequencer #(.WIDTH(2), .CNT_W(8)) dut2 (
      .CLK(CLK), .RESET(RESET), .start(start), .cycles(cycles), .hold(hold),
      .stop(stop), .O(O), .phase(phase), .wrap(wrap), .busy(busy), .done(done));

   johnson_phase_sequencer #(.WIDTH(3), .CNT_W(8)) dut3 (
      .CLK(CLK), .RESET(r3), .start(s3), .cycles(c3), .hold(h3),
      .stop(p3), .O(O3), .phase(ph3), .wrap(w3), .busy(b3), .done(d3));

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one edge, sample 1 time unit later, tally dut2 activity.
   task automatic tick();
      @(posedge CLK);
      #1;
      if (busy) bcnt++;
      if (done) dcnt++;
      if (wrap) wcnt++;
   endtask

   task automatic clr_cnt();
      bcnt = 0; dcnt = 0; wcnt = 0;
   endtask

   // Ring code k steps from zero: k ones filling from the bottom, then
   // zeros filling from the bottom.
   function automatic logic [31:0] code_of(input int k, input int w);
      logic [31:0] full;
      full = (32'd1 << w) - 32'd1;
      if (k <= w) return (32'd1 << k) - 32'd1;
      return full & ~((32'd1 << (k - w)) - 32'd1);
   endfunction

   // Reference model: phase position, revolutions left, run mode.
   localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;
   int m_st, m_k, m_rem;
   bit m_wrap;

   task automatic model_step(input bit rst, input bit st, input int cyc,
                             input bit hd, input bit sp, input int w);
      m_wrap = 0;
      if (rst) begin
         m_st = M_IDLE; m_k = 0; m_rem = 0;
      end else begin
         case (m_st)
            M_IDLE: begin
               m_k = 0;
               if (st) begin
                  if (cyc == 0) m_st = M_DONE;
                  else begin m_st = M_RUN; m_rem = cyc; end
               end
            end
            M_RUN: begin
               if (sp) begin m_st = M_IDLE; m_k = 0; m_rem = 0; end
               else if (hd) m_st = M_HOLD;
               else begin
                  m_k = (m_k + 1) % (2 * w);
                  if (m_k == 0) begin
                     m_wrap = 1;
                     m_rem  = m_rem - 1;
                     if (m_rem == 0) m_st = M_DONE;
                  end
               end
            end
            M_HOLD: begin
               if (sp) begin m_st = M_IDLE; m_k = 0; m_rem = 0; end
               else if (!hd) m_st = M_RUN;
            end
            default: begin m_st = M_IDLE; m_k = 0; end
         endcase
      end
   endtask

   typedef struct {
      logic       st;
      logic [7:0] cyc;
      logic       hd;
      logic       sp;
      logic [1:0] e_o;
      logic [3:0] e_ph;
      logic       e_wrap;
      logic       e_busy;
      logic       e_done;
   } vec_t;

   vec_t tbl[16];

   initial begin
      logic [31:0] exp_o;
      logic [8:0]  act_v, exp_v;

      // start, cycles, hold, stop | O, phase, wrap, busy, done
      tbl[0]  = '{1'b1, 8'd3, 1'b0, 1'b0, 2'b00, 4'b0001, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 8'd0, 1'b0, 1'b0, 2'b01, 4'b0010, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 8'd0, 1'b0, 1'b0, 2'b11, 4'b0100, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 8'd0, 1'b0, 1'b0, 2'b10, 4'b1000, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 8'd0, 1'b0, 1'b0, 2'b00, 4'b0001, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 8'd7, 1'b0, 1'b0, 2'b01, 4'b0010, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 8'd0, 1'b0, 1'b0, 2'b11, 4'b0100, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 8'd0, 1'b0, 1'b0, 2'b10, 4'b1000, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 8'd0, 1'b0, 1'b0, 2'b00, 4'b0001, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 8'd0, 1'b0, 1'b0, 2'b01, 4'b0010, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 8'd0, 1'b0, 1'b0, 2'b11, 4'b0100, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 8'd0, 1'b0, 1'b0, 2'b10, 4'b1000, 1'b0, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 8'd0, 1'b0, 1'b0, 2'b00, 4'b0001, 1'b1, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 8'd0, 1'b0, 1'b1, 2'b00, 4'b0001, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 8'd0, 1'b0, 1'b0, 2'b00, 4'b0001, 1'b0, 1'b0, 1'b1};
      tbl[15] = '{1'b0, 8'd0, 1'b0, 1'b0, 2'b00, 4'b0001, 1'b0, 1'b0, 1'b0};

      RESET = 1'b1; start = 1'b0; cycles = 8'd0; hold = 1'b0; stop = 1'b0;
      r3 = 1'b1; s3 = 1'b0; c3 = 8'd0; h3 = 1'b0; p3 = 1'b0;
      clr_cnt();
      tick();
      chk("reset_O", 32'(O), 32'd0);
      chk("reset_phase", 32'(phase), 32'd1);
      chk("reset_flags", {29'd0, wrap, busy, done}, 32'd0);
      chk("reset3_phase", 32'(ph3), 32'd1);
      RESET = 1'b0; r3 = 1'b0;

      // Table: 3 revolutions, ignored restart, stop in IDLE, cycles=0.
      for (int i = 0; i < 16; i++) begin
         start = tbl[i].st; cycles = tbl[i].cyc; hold = tbl[i].hd; stop = tbl[i].sp;
         tick();
         chk($sformatf("tbl%0d_O", i), 32'(O), 32'(tbl[i].e_o));
         chk($sformatf("tbl%0d_phase", i), 32'(phase), 32'(tbl[i].e_ph));
         chk($sformatf("tbl%0d_wbd", i), {29'd0, wrap, busy, done},
             {29'd0, tbl[i].e_wrap, tbl[i].e_busy, tbl[i].e_done});
      end
      start = 1'b0; stop = 1'b0;

      // Hold at O=11 for two edges, plus the resume edge: 3 extra busy cycles.
      clr_cnt();
      start = 1'b1; cycles = 8'd2; tick(); start = 1'b0;
      tick(); tick();
      chk("hold_pre_O", 32'(O), 32'b11);
      hold = 1'b1; tick();
      chk("hold_e3_O", 32'(O), 32'b11);
      tick();
      chk("hold_e4_O", 32'(O), 32'b11);
      chk("hold_busy", 32'(busy), 32'd1);
      hold = 1'b0; tick();
      chk("hold_resume_O", 32'(O), 32'b11);
      tick();
      chk("hold_step_O", 32'(O), 32'b10);
      for (int i = 0; i < 10; i++) tick();
      chk("hold_busy_cnt", 32'(bcnt), 32'd11);
      chk("hold_done_cnt", 32'(dcnt), 32'd1);
      chk("hold_wrap_cnt", 32'(wcnt), 32'd2);

      // Stop at O=01 in revolution 2, then a fresh 5-revolution run.
      clr_cnt();
      start = 1'b1; cycles = 8'd5; tick(); start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("stop_pre_O", 32'(O), 32'b01);
      stop = 1'b1; tick(); stop = 1'b0;
      chk("stop_O", 32'(O), 32'd0);
      chk("stop_flags", {29'd0, wrap, busy, done}, 32'd0);
      for (int i = 0; i < 4; i++) tick();
      chk("stop_no_done", 32'(dcnt), 32'd0);
      clr_cnt();
      start = 1'b1; cycles = 8'd5; tick(); start = 1'b0;
      for (int i = 0; i < 25; i++) tick();
      chk("rerun_busy_cnt", 32'(bcnt), 32'd20);
      chk("rerun_done_cnt", 32'(dcnt), 32'd1);
      chk("rerun_wrap_cnt", 32'(wcnt), 32'd5);

      // stop and hold together in RUN: stop wins.
      clr_cnt();
      start = 1'b1; cycles = 8'd3; tick(); start = 1'b0;
      tick();
      stop = 1'b1; hold = 1'b1; tick(); stop = 1'b0; hold = 1'b0;
      chk("stophold_busy", 32'(busy), 32'd0);
      chk("stophold_O", 32'(O), 32'd0);
      for (int i = 0; i < 5; i++) tick();
      chk("stophold_no_done", 32'(dcnt), 32'd0);

      // Forced O=10 with one revolution: next step wraps and completes.
      start = 1'b1; cycles = 8'd1; tick(); start = 1'b0;
      force dut2.u_core.ring_q = 2'b10;
      #1;
      release dut2.u_core.ring_q;
      chk("force10_phase", 32'(phase), 32'b1000);
      tick();
      chk("force10_O", 32'(O), 32'd0);
      chk("force10_flags", {29'd0, wrap, busy, done}, 32'b101);
      tick();
      chk("force10_after", {29'd0, wrap, busy, done}, 32'd0);

      // RESET mid-run overrides a concurrent start.
      start = 1'b1; cycles = 8'd4; tick(); start = 1'b0;
      tick(); tick();
      RESET = 1'b1; start = 1'b1; tick();
      chk("midreset_O", 32'(O), 32'd0);
      chk("midreset_phase", 32'(phase), 32'd1);
      chk("midreset_flags", {29'd0, wrap, busy, done}, 32'd0);
      RESET = 1'b0; start = 1'b0; tick();
      chk("midreset_idle", 32'(busy), 32'd0);

      // Maximum revolution count runs to completion without underflow.
      clr_cnt();
      start = 1'b1; cycles = 8'd255; tick(); start = 1'b0;
      for (int i = 0; i < 1025; i++) tick();
      chk("max_busy_cnt", 32'(bcnt), 32'd1020);
      chk("max_done_cnt", 32'(dcnt), 32'd1);
      chk("max_wrap_cnt", 32'(wcnt), 32'd255);

      // WIDTH=3: illegal code 010 decodes to no phase and clears next edge.
      s3 = 1'b1; c3 = 8'd2; tick(); s3 = 1'b0;
      tick();
      chk("w3_step_O", 32'(O3), 32'b001);
      force dut3.u_core.ring_q = 3'b010;
      #1;
      release dut3.u_core.ring_q;
      chk("w3_illegal_phase", 32'(ph3), 32'd0);
      tick();
      chk("w3_cleared_O", 32'(O3), 32'd0);
      chk("w3_still_busy", 32'(b3), 32'd1);
      r3 = 1'b1; tick(); r3 = 1'b0;

      // Randomized run against the reference model.
      RESET = 1'b1; tick();
      model_step(1'b1, 1'b0, 0, 1'b0, 1'b0, 2);
      for (int n = 0; n < 4000; n++) begin
         RESET  = ($urandom_range(0, 199) == 0);
         start  = ($urandom_range(0, 3) == 0);
         cycles = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(0, 3));
         hold   = ($urandom_range(0, 4) == 0);
         stop   = ($urandom_range(0, 29) == 0);
         model_step(RESET, start, int'(cycles), hold, stop, 2);
         tick();
         exp_o = code_of(m_k, 2);
         exp_v = {exp_o[1:0], 4'(32'd1 << m_k), m_wrap,
                  (m_st == M_RUN || m_st == M_HOLD), (m_st == M_DONE)};
         act_v = {O, phase, wrap, busy, done};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL rand%0d: got O=%b ph=%b w=%b b=%b d=%b expected O=%b ph=%b w=%b b=%b d=%b",
                     n, act_v[8:7], act_v[6:3], act_v[2], act_v[1], act_v[0],
                     exp_v[8:7], exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/johnson_phase_sequencer.md
Name: johnson_phase_sequencer

Overview:
- Controller for a WIDTH-stage Johnson (twisted-ring) counter.
- Runs the ring for a programmed number of full revolutions, then stops and pulses done.
- Supports a start/busy/done handshake, hold (pause) and stop (abort).
- Exposes the raw ring state and a one-hot phase decode so downstream logic can be sequenced on 2*WIDTH phases.

Parameters:
- WIDTH, 2, Johnson stages; the ring has 2*WIDTH states (WIDTH >= 2).
- CNT_W, 8, width of the revolution count.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- cycles  input  CNT_W  number of full revolutions; latched when start is accepted.
- hold  input  1  freeze the ring while asserted (RUN/HOLD only).
- stop  input  1  abort the run and return to IDLE.
- O  output  WIDTH  Johnson ring state.
- phase  output  2*WIDTH  one-hot decode of O; phase[k] = ring is at step k from all-zero.
- wrap  output  1  high for the one cycle in which O has just returned to all-zero while in RUN.
- busy  output  1  high in RUN and HOLD.
- done  output  1  one-cycle pulse at normal completion.

Behaviour:
- Reset values: on RESET=1 at an edge, state=IDLE, O=0, remaining=0, wrap=0, busy=0, done=0, phase=1 (bit 0). RESET overrides every other input.
- Ring step: O_next = {O[WIDTH-2:0], ~O[WIDTH-1]}.
  - WIDTH=2 sequence: 00 -> 01 -> 11 -> 10 -> 00.
  - Phase index k counts steps from 00.
- Illegal ring values (not one of the 2*WIDTH legal codes) are forced to 0 on the next edge in any state. phase is all-zero while O is illegal.
- States: IDLE, RUN, HOLD, DONE.
  - IDLE: O held at 0. start=1 -> RUN, remaining <= cycles, O unchanged.
  - IDLE with start=1 and cycles=0 -> DONE directly; no ring steps.
  - RUN: O steps every edge. When a step produces O=0: wrap=1 next cycle, remaining decrements. If remaining becomes 0 on that edge -> DONE.
  - RUN with hold=1 -> HOLD. The step on that edge is suppressed.
  - HOLD: O, remaining frozen. hold=0 -> RUN; stepping resumes on the following edge.
  - DONE: done=1, busy=0, O=0. Always -> IDLE on the next edge.
- Priority within an edge: RESET > stop > hold > step/start.
- stop in RUN or HOLD -> IDLE: O <= 0, remaining <= 0, no done, no wrap.
- stop in IDLE/DONE has no effect beyond normal transitions.
- start while busy or in DONE is ignored; cycles changes after acceptance are ignored.
- Latency, start accepted at edge 0:
  - busy high from edge 0 until edge 2*WIDTH*cycles, with no hold.
  - done high in the cycle after edge 2*WIDTH*cycles.
  - wrap high after edges 2*WIDTH*n, n = 1..cycles.
- remaining never underflows. cycles = 2^CNT_W-1 is legal.
- wrap and done coincide in the final cycle. O reads 0 in that cycle.
- All outputs are registered or decoded from registers only; no combinational input-to-output paths.

Decomposition:
- Shared package johnson_pkg:
  - state enum (IDLE, RUN, HOLD, DONE);
  - function johnson_next(O);
  - function johnson_legal(O);
  - function johnson_decode(O) -> one-hot phase.
- Sub-module johnson_core: WIDTH-bit ring register with enable and synchronous clear; outputs O and wrap_now (comb: next value is 0).
- Top level holds the FSM, the remaining counter and the output registers.

Test Plan:
- RESET, then WIDTH=2, start=1, cycles=3, no hold -> O sequence 00,01,11,10 repeated 3x; wrap high at edges 4,8,12; done one cycle after edge 12; busy high 12 cycles.
- start with cycles=0 -> done one cycle after acceptance, busy never high, O stays 00, wrap never high.
- cycles=2, hold=1 for 3 cycles while O=11 -> O frozen at 11 for 3 cycles, busy stays 1, total busy = 8+3 cycles, done once.
- cycles=5, stop=1 while O=01 in revolution 2 -> next cycle IDLE, O=00, busy=0, done never pulses; a fresh start then runs 5 full revolutions.
- stop and hold asserted together in RUN -> IDLE (stop wins). start pulsed during RUN -> ignored, count unaffected.
- Force O=10 with cycles=1 (ring-wrap equivalent); separately force illegal O=... (WIDTH=3: 010) -> O=000 next edge, phase=0 during the illegal cycle. RESET asserted mid-run -> all outputs at reset values next cycle.
